// File: rtl/seg7_disp_logic.sv
// rtl/seg7_disp_logic.sv - bus-writable 4-digit multiplexed 7-segment display driver
//
// Purpose:
//   The CPU writes two registers through the 2-register IPIF slave attachment.
//   The block scans a common-anode 4-digit display from those registers.
//     DATA (0x00): [15:0] hex nibbles (digit k = [4k+3:4k]), [19:16] decimal points
//     CTRL (0x04): [0] EN, [1] BLINK, [7:4] per-digit MASK
//
// Ports:
//   Bus2IP_Clk     clock (the only clock)
//   Bus2IP_Resetn  asynchronous active-low reset
//   Bus2IP_Data    write data
//   Bus2IP_BE      byte enables for Bus2IP_Data
//   Bus2IP_RdCE    read chip enables, [1] = DATA, [0] = CTRL
//   Bus2IP_WrCE    write chip enables, same mapping
//   IP2Bus_Data    combinational read data
//   IP2Bus_RdAck   read acknowledge, same cycle as the enable
//   IP2Bus_WrAck   write acknowledge, same cycle as the enable
//   IP2Bus_Error   always 0
//   seg_n          active-low segments, bit0 = a .. bit6 = g, bit7 = dp
//   dig_n          active-low digit anodes, bit0 = rightmost digit
module seg7_disp_logic #(
  parameter int C_NUM_REG    = 2,
  parameter int C_SLV_DWIDTH = 32,
  parameter int C_SCAN_DIV   = 16384,
  parameter int C_BLINK_DIV  = 64
) (
  input  logic                      Bus2IP_Clk,
  input  logic                      Bus2IP_Resetn,
  input  logic [C_SLV_DWIDTH-1:0]   Bus2IP_Data,
  input  logic [C_SLV_DWIDTH/8-1:0] Bus2IP_BE,
  input  logic [C_NUM_REG-1:0]      Bus2IP_RdCE,
  input  logic [C_NUM_REG-1:0]      Bus2IP_WrCE,
  output logic [C_SLV_DWIDTH-1:0]   IP2Bus_Data,
  output logic                      IP2Bus_RdAck,
  output logic                      IP2Bus_WrAck,
  output logic                      IP2Bus_Error,
  output logic [7:0]                seg_n,
  output logic [3:0]                dig_n
);

  localparam int PW = (C_SCAN_DIV > 1) ? $clog2(C_SCAN_DIV) : 1;
  localparam int BW = (C_BLINK_DIV > 1) ? $clog2(C_BLINK_DIV) : 1;
  localparam logic [PW-1:0] SCAN_LAST  = PW'(C_SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(C_BLINK_DIV - 1);

  logic [19:0]   data_q;
  logic          en_q;
  logic          blink_q;
  logic [3:0]    mask_q;

  logic [PW-1:0] prescale_q;
  logic [1:0]    idx_q;
  logic [BW-1:0] blink_cnt_q;
  logic          phase_q;

  logic          tick;
  logic [1:0]    next_idx;
  logic [3:0]    nibble;
  logic          dp;
  logic          visible;
  logic [6:0]    seg_dec;

  // Data bits [31:20] and the top byte enable have no storage behind them.
  logic unused_bits;
  assign unused_bits = &{1'b0, Bus2IP_Data[31:20], Bus2IP_BE[3]};

  // Register writes, byte-qualified.
  always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
    if (!Bus2IP_Resetn) begin
      data_q  <= '0;
      en_q    <= 1'b0;
      blink_q <= 1'b0;
      mask_q  <= '0;
    end else begin
      if (Bus2IP_WrCE[1]) begin
        if (Bus2IP_BE[0]) data_q[7:0]   <= Bus2IP_Data[7:0];
        if (Bus2IP_BE[1]) data_q[15:8]  <= Bus2IP_Data[15:8];
        if (Bus2IP_BE[2]) data_q[19:16] <= Bus2IP_Data[19:16];
      end
      if (Bus2IP_WrCE[0] && Bus2IP_BE[0]) begin
        en_q    <= Bus2IP_Data[0];
        blink_q <= Bus2IP_Data[1];
        mask_q  <= Bus2IP_Data[7:4];
      end
    end
  end

  always_comb begin
    IP2Bus_Data = '0;
    case (Bus2IP_RdCE)
      2'b10:   IP2Bus_Data = {12'b0, data_q};
      2'b01:   IP2Bus_Data = {24'b0, mask_q, 2'b00, blink_q, en_q};
      default: IP2Bus_Data = '0;
    endcase
  end

  assign IP2Bus_RdAck = |Bus2IP_RdCE;
  assign IP2Bus_WrAck = |Bus2IP_WrCE;
  assign IP2Bus_Error = 1'b0;

  // Everything on the pins is prepared for the slot about to start, so the
  // values are taken for the next index rather than the current one.
  assign tick     = (prescale_q == SCAN_LAST);
  assign next_idx = idx_q + 2'd1;
  assign nibble   = data_q[{next_idx, 2'b00} +: 4];
  assign dp       = data_q[16 + next_idx];
  assign visible  = en_q & mask_q[next_idx] & (~blink_q | phase_q);

  // Active-low {g,f,e,d,c,b,a}.
  always_comb begin
    seg_dec = 7'h7F;
    case (nibble)
      4'h0: seg_dec = 7'h40;
      4'h1: seg_dec = 7'h79;
      4'h2: seg_dec = 7'h24;
      4'h3: seg_dec = 7'h30;
      4'h4: seg_dec = 7'h19;
      4'h5: seg_dec = 7'h12;
      4'h6: seg_dec = 7'h02;
      4'h7: seg_dec = 7'h78;
      4'h8: seg_dec = 7'h00;
      4'h9: seg_dec = 7'h10;
      4'hA: seg_dec = 7'h08;
      4'hB: seg_dec = 7'h03;
      4'hC: seg_dec = 7'h46;
      4'hD: seg_dec = 7'h21;
      4'hE: seg_dec = 7'h06;
      4'hF: seg_dec = 7'h0E;
      default: seg_dec = 7'h7F;
    endcase
  end

  // Scan, blink and pin registers. The frame tick lights digit 0 with the
  // phase that the frame's other three digits used, and only then toggles,
  // so each 1-2-3-0 group is uniformly lit or blank.
  always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
    if (!Bus2IP_Resetn) begin
      prescale_q  <= '0;
      idx_q       <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
      seg_n       <= 8'hFF;
      dig_n       <= 4'hF;
    end else begin
      prescale_q <= tick ? '0 : prescale_q + 1'b1;
      if (tick) begin
        idx_q <= next_idx;
        if (idx_q == 2'd3) begin
          if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_q <= '0;
            phase_q     <= ~phase_q;
          end else begin
            blink_cnt_q <= blink_cnt_q + 1'b1;
          end
        end
        if (visible) begin
          dig_n <= ~(4'b0001 << next_idx);
          seg_n <= {~dp, seg_dec};
        end else begin
          dig_n <= 4'hF;
          seg_n <= 8'hFF;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_disp_logic.sv
// tb/tb_seg7_disp_logic.sv - directed self-checking bench for seg7_disp_logic
module tb_seg7_disp_logic;

  logic        clk;
  logic        rst_n;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic [1:0]  rdce;
  logic [1:0]  wrce;
  logic [31:0] rdata;
  logic        rdack;
  logic        wrack;
  logic        err;
  logic [7:0]  seg_n;
  logic [3:0]  dig_n;

  int n_vec = 0;
  int n_bad = 0;

  seg7_disp_logic #(
    .C_NUM_REG(2),
    .C_SLV_DWIDTH(32),
    .C_SCAN_DIV(4),
    .C_BLINK_DIV(2)
  ) dut (
    .Bus2IP_Clk(clk),
    .Bus2IP_Resetn(rst_n),
    .Bus2IP_Data(wdata),
    .Bus2IP_BE(be),
    .Bus2IP_RdCE(rdce),
    .Bus2IP_WrCE(wrce),
    .IP2Bus_Data(rdata),
    .IP2Bus_RdAck(rdack),
    .IP2Bus_WrAck(wrack),
    .IP2Bus_Error(err),
    .seg_n(seg_n),
    .dig_n(dig_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reset is released on a falling edge; the next rising edge is cycle 1.
  task automatic apply_reset();
    rst_n = 1'b0;
    rdce  = 2'b00;
    wrce  = 2'b00;
    be    = 4'h0;
    wdata = 32'h0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Write captured on the next rising edge; returns on the following falling edge.
  task automatic bus_write(input logic [1:0] ce, input logic [31:0] d, input logic [3:0] b);
    wrce  = ce;
    wdata = d;
    be    = b;
    @(negedge clk);
    wrce  = 2'b00;
    be    = 4'h0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rdce  = 2'b00;
    wrce  = 2'b00;
    be    = 4'h0;
    wdata = 32'h0;
    @(negedge clk);
    @(negedge clk);
    n_vec++; if (seg_n !== 8'hFF) begin n_bad++; $display("FAIL rst_seg got %h want FF", seg_n); end
    n_vec++; if (dig_n !== 4'hF) begin n_bad++; $display("FAIL rst_dig got %h want F", dig_n); end
    rst_n = 1'b1;
    @(negedge clk);
    rdce = 2'b10; #1;
    n_vec++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL rst_data got %h want 0", rdata); end
    rdce = 2'b01; #1;
    n_vec++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL rst_ctrl got %h want 0", rdata); end
    n_vec++; if (rdack !== 1'b1) begin n_bad++; $display("FAIL rdack_hi got %b want 1", rdack); end
    rdce = 2'b00; #1;
    n_vec++; if (rdack !== 1'b0) begin n_bad++; $display("FAIL rdack_lo got %b want 0", rdack); end
    n_vec++; if (wrack !== 1'b0) begin n_bad++; $display("FAIL wrack_lo got %b want 0", wrack); end
    n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL error got %b want 0", err); end
    wrce = 2'b01; be = 4'h0; #1;
    n_vec++; if (wrack !== 1'b1) begin n_bad++; $display("FAIL wrack_hi got %b want 1", wrack); end
    @(negedge clk);
    wrce = 2'b00; #1;
    n_vec++; if (wrack !== 1'b0) begin n_bad++; $display("FAIL wrack_end got %b want 0", wrack); end
    rdce = 2'b01; #1;
    n_vec++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL be0_ctrl got %h want 0", rdata); end
    rdce = 2'b00;
  endtask

  task automatic test_registers();
    apply_reset();
    bus_write(2'b10, 32'hFFFF_FFFF, 4'hF);
    bus_write(2'b01, 32'hFFFF_FFFF, 4'hF);
    rdce = 2'b10; #1;
    n_vec++; if (rdata !== 32'h000F_FFFF) begin n_bad++; $display("FAIL data_mask got %h want 000FFFFF", rdata); end
    rdce = 2'b01; #1;
    n_vec++; if (rdata !== 32'h0000_00F3) begin n_bad++; $display("FAIL ctrl_mask got %h want 000000F3", rdata); end
    rdce = 2'b00; #1;
    n_vec++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL rd_none got %h want 0", rdata); end
  endtask

  task automatic test_scan();
    logic [7:0] exp_seg [4];
    logic [7:0] es;
    logic [3:0] ed;
    int k;
    exp_seg[0] = 8'h0E; exp_seg[1] = 8'hB0; exp_seg[2] = 8'h88; exp_seg[3] = 8'h80;
    apply_reset();
    bus_write(2'b10, 32'h0001_8A3F, 4'hF);
    bus_write(2'b01, 32'h0000_00F1, 4'hF);
    for (int n = 3; n < 20; n++) begin
      @(negedge clk);
      k = (n / 4) % 4;
      es = (n < 4) ? 8'hFF : exp_seg[k];
      ed = (n < 4) ? 4'hF : ~(4'b0001 << k);
      n_vec++; if (dig_n !== ed) begin n_bad++; $display("FAIL scan_dig c%0d got %h want %h", n, dig_n, ed); end
      n_vec++; if (seg_n !== es) begin n_bad++; $display("FAIL scan_seg c%0d got %h want %h", n, seg_n, es); end
    end
  endtask

  task automatic test_partial_write();
    apply_reset();
    bus_write(2'b10, 32'h0000_1234, 4'hF);
    bus_write(2'b10, 32'h0000_00AB, 4'b0001);
    bus_write(2'b01, 32'h0000_00F1, 4'hF);
    rdce = 2'b10; #1;
    n_vec++; if (rdata !== 32'h0000_12AB) begin n_bad++; $display("FAIL pw_read got %h want 000012AB", rdata); end
    rdce = 2'b00;
    for (int n = 4; n < 17; n++) @(negedge clk);
    n_vec++; if (dig_n !== 4'hE) begin n_bad++; $display("FAIL pw_dig got %h want E", dig_n); end
    n_vec++; if (seg_n !== 8'h83) begin n_bad++; $display("FAIL pw_seg got %h want 83", seg_n); end
  endtask

  task automatic test_mask_enable();
    logic [7:0] es;
    logic [3:0] ed;
    int k;
    apply_reset();
    bus_write(2'b01, 32'h0000_0051, 4'hF);
    for (int n = 2; n < 20; n++) begin
      @(negedge clk);
      k = (n / 4) % 4;
      if (n >= 4 && (k == 0 || k == 2)) begin
        ed = ~(4'b0001 << k);
        es = 8'hC0;
      end else begin
        ed = 4'hF;
        es = 8'hFF;
      end
      n_vec++; if (dig_n !== ed) begin n_bad++; $display("FAIL mask_dig c%0d got %h want %h", n, dig_n, ed); end
      n_vec++; if (seg_n !== es) begin n_bad++; $display("FAIL mask_seg c%0d got %h want %h", n, seg_n, es); end
    end
    apply_reset();
    bus_write(2'b01, 32'h0000_00F0, 4'hF);
    for (int n = 2; n < 20; n++) begin
      @(negedge clk);
      n_vec++; if (dig_n !== 4'hF) begin n_bad++; $display("FAIL en0_dig c%0d got %h want F", n, dig_n); end
    end
  endtask

  task automatic test_blink();
    logic [3:0] ed;
    int k;
    int f;
    apply_reset();
    bus_write(2'b01, 32'h0000_00F3, 4'hF);
    for (int n = 2; n < 68; n++) begin
      @(negedge clk);
      k = (n / 4) % 4;
      f = (n - 4) / 16;
      ed = (n >= 4 && ((f / 2) % 2) == 0) ? ~(4'b0001 << k) : 4'hF;
      n_vec++; if (dig_n !== ed) begin n_bad++; $display("FAIL blink_dig c%0d got %h want %h", n, dig_n, ed); end
    end
    apply_reset();
    bus_write(2'b01, 32'h0000_00F1, 4'hF);
    for (int n = 2; n < 68; n++) begin
      @(negedge clk);
      k = (n / 4) % 4;
      ed = (n >= 4) ? ~(4'b0001 << k) : 4'hF;
      n_vec++; if (dig_n !== ed) begin n_bad++; $display("FAIL steady_dig c%0d got %h want %h", n, dig_n, ed); end
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    bus_write(2'b10, 32'h0000_1234, 4'hF);
    bus_write(2'b01, 32'h0000_00F1, 4'hF);
    for (int n = 3; n < 10; n++) @(negedge clk);
    n_vec++; if (dig_n !== 4'hB) begin n_bad++; $display("FAIL pre_dig got %h want B", dig_n); end
    n_vec++; if (seg_n !== 8'hA4) begin n_bad++; $display("FAIL pre_seg got %h want A4", seg_n); end
    rdce = 2'b11; #1;
    n_vec++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL rd11 got %h want 0", rdata); end
    n_vec++; if (rdack !== 1'b1) begin n_bad++; $display("FAIL rd11_ack got %b want 1", rdack); end
    rdce = 2'b00;
    #1 rst_n = 1'b0;
    #1;
    n_vec++; if (dig_n !== 4'hF) begin n_bad++; $display("FAIL async_dig got %h want F", dig_n); end
    n_vec++; if (seg_n !== 8'hFF) begin n_bad++; $display("FAIL async_seg got %h want FF", seg_n); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bus_write(2'b01, 32'h0000_00F1, 4'hF);
    for (int n = 2; n < 5; n++) begin
      @(negedge clk);
      if (n < 4) begin
        n_vec++; if (dig_n !== 4'hF) begin n_bad++; $display("FAIL rel_blank c%0d got %h want F", n, dig_n); end
      end else begin
        n_vec++; if (dig_n !== 4'hD) begin n_bad++; $display("FAIL rel_dig got %h want D", dig_n); end
        n_vec++; if (seg_n !== 8'hC0) begin n_bad++; $display("FAIL rel_seg got %h want C0", seg_n); end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    rdce  = 2'b00;
    wrce  = 2'b00;
    be    = 4'h0;
    wdata = 32'h0;
    test_reset();
    test_registers();
    test_scan();
    test_partial_write();
    test_mask_enable();
    test_blink();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
